load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 214 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte-addressed requests to a word-addressed memory without byte enables.
// Optional macro LSU_PERF_CNT_EN builds load/store/error response counters.
module load_store_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    output logic                  mem_write_enable_o,
    input  logic [DATA_WIDTH-1:0] mem_read_data_i,
    output logic [DATA_WIDTH-1:0] load_count_o,
    output logic [DATA_WIDTH-1:0] store_count_o,
    output logic [DATA_WIDTH-1:0] err_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [1:0]            r_lane;
    logic [2:0]            r_funct3;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_is_load;
    logic [DATA_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic                  w_accept;
    logic                  w_bad_funct3;
    logic                  w_misaligned;
    logic                  w_out_of_range;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_word_idx;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic [4:0]            w_shift;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_merged;

    assign req_ready_o = (r_state == S_IDLE);
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_word_idx  = {2'b00, req_addr_i[DATA_WIDTH-1:2]};

    always_comb begin
        w_bad_funct3 = 1'b0;
        if (req_we_i)
            w_bad_funct3 = (req_funct3_i[2] || (req_funct3_i[1:0] == 2'd3));
        else
            w_bad_funct3 = (req_funct3_i[1:0] == 2'd3) || (req_funct3_i == 3'd6);
        w_misaligned   = ((req_funct3_i[1:0] == 2'd1) && req_addr_i[0])
                      || ((req_funct3_i[1:0] == 2'd2) && (req_addr_i[1:0] != 2'b00));
        w_out_of_range = (w_word_idx >= DATA_WIDTH'(MEMORY_DEPTH));
        w_err          = w_bad_funct3 || w_misaligned || w_out_of_range;
    end

    // Lane extraction and sign/zero extension of the memory word for loads.
    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = mem_read_data_i[7:0];
            2'd1:    w_byte = mem_read_data_i[15:8];
            2'd2:    w_byte = mem_read_data_i[23:16];
            default: w_byte = mem_read_data_i[31:24];
        endcase
        w_half = r_lane[1] ? mem_read_data_i[31:16] : mem_read_data_i[15:0];
        case (r_funct3)
            3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
            3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
            3'd4:    w_load_data = {24'h000000, w_byte};
            3'd5:    w_load_data = {16'h0000, w_half};
            default: w_load_data = mem_read_data_i;
        endcase
    end

    always_comb begin
        w_shift = 5'd0;
        w_mask  = '0;
        if (r_funct3[0]) begin
            w_shift = {r_lane[1], 4'b0000};
            w_mask  = 32'h0000_FFFF << w_shift;
        end else begin
            w_shift = {r_lane, 3'b000};
            w_mask  = 32'h0000_00FF << w_shift;
        end
        w_merged = (mem_read_data_i & ~w_mask) | ((r_wdata << w_shift) & w_mask);
    end

    // NOTE: write enable is decoded from state, not registered, so an async reset drops it immediately.
    assign mem_write_enable_o = (r_state == S_STORE) || (r_state == S_RMW_WR);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_lane        <= 2'b00;
            r_funct3      <= 3'd0;
            r_wdata       <= '0;
            r_is_load     <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_lane    <= req_addr_i[1:0];
                        r_funct3  <= req_funct3_i;
                        r_wdata   <= req_wdata_i;
                        r_is_load <= !req_we_i;
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            r_mem_address <= w_word_idx;
                            if (!req_we_i) begin
                                r_state <= S_LOAD;
                            end else if (req_funct3_i[1:0] == 2'd2) begin
                                r_mem_wdata <= req_wdata_i;
                                r_state     <= S_STORE;
                            end else begin
                                r_state <= S_RMW_RD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    r_rsp_rdata <= w_load_data;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_STORE: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RMW_RD: begin
                    r_mem_wdata <= w_merged;
                    r_state     <= S_RMW_WR;
                end
                S_RMW_WR: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_address_o    = r_mem_address;
    assign mem_write_data_o = r_mem_wdata;
    assign rsp_valid_o      = r_rsp_valid;
    assign rsp_rdata_o      = r_rsp_rdata;
    assign rsp_err_o        = r_rsp_err;

`ifdef LSU_PERF_CNT_EN
    logic [DATA_WIDTH-1:0] r_load_count;
    logic [DATA_WIDTH-1:0] r_store_count;
    logic [DATA_WIDTH-1:0] r_err_count;

    // Each response is counted once, in its RESP cycle; counters wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_load_count  <= '0;
            r_store_count <= '0;
            r_err_count   <= '0;
        end else if (r_state == S_RESP) begin
            if (r_rsp_err)
                r_err_count <= r_err_count + 1'b1;
            else if (r_is_load)
                r_load_count <= r_load_count + 1'b1;
            else
                r_store_count <= r_store_count + 1'b1;
        end
    end

    assign load_count_o  = r_load_count;
    assign store_count_o = r_store_count;
    assign err_count_o   = r_err_count;
`else
    assign load_count_o  = '0;
    assign store_count_o = '0;
    assign err_count_o   = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural word memory.
// Counter checks follow LSU_PERF_CNT_EN; the default build expects the counter ports at 0.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_write_data_o;
    logic        mem_write_enable_o;
    logic [31:0] mem_read_data_i;
    logic [31:0] load_count_o;
    logic [31:0] store_count_o;
    logic [31:0] err_count_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_loads = 0;
    int exp_stores = 0;
    int exp_errs = 0;

    logic [31:0] mem [0:1023];

    always #5 clk_i = ~clk_i;

    assign mem_read_data_i = mem_write_enable_o ? 32'h0 : mem[mem_address_o[9:0]];

    always @(posedge clk_i)
        if (mem_write_enable_o)
            mem[mem_address_o[9:0]] <= mem_write_data_o;

    load_store_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(1024)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .req_valid_i        (req_valid_i),
        .req_ready_o        (req_ready_o),
        .req_we_i           (req_we_i),
        .req_funct3_i       (req_funct3_i),
        .req_addr_i         (req_addr_i),
        .req_wdata_i        (req_wdata_i),
        .rsp_valid_o        (rsp_valid_o),
        .rsp_rdata_o        (rsp_rdata_o),
        .rsp_err_o          (rsp_err_o),
        .mem_address_o      (mem_address_o),
        .mem_write_data_o   (mem_write_data_o),
        .mem_write_enable_o (mem_write_enable_o),
        .mem_read_data_i    (mem_read_data_i),
        .load_count_o       (load_count_o),
        .store_count_o      (store_count_o),
        .err_count_o        (err_count_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request and watches until the response pulse, recording every write strobe.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                         output logic err, output int n_wr, output int wr_cyc,
                         output logic [31:0] wr_addr, output logic [31:0] wr_data);
        lat = 0; rdata = '0; err = 1'b0; n_wr = 0; wr_cyc = 0; wr_addr = '0; wr_data = '0;
        @(negedge clk_i);
        check("ready_before_req", {31'b0, req_ready_o}, 32'd1);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        @(posedge clk_i);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
            if (mem_write_enable_o) begin
                n_wr++;
                wr_cyc  = k;
                wr_addr = mem_address_o;
                wr_data = mem_write_data_o;
            end
            if (rsp_valid_o) begin
                lat   = k;
                rdata = rsp_rdata_o;
                err   = rsp_err_o;
                break;
            end
        end
        if (lat == 0)
            check("rsp_timeout", 32'd0, 32'd1);
        if (err)
            exp_errs++;
        else if (we)
            exp_stores++;
        else
            exp_loads++;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp);
        int lat, n_wr, wr_cyc;
        logic [31:0] rdata, wa, wd;
        logic err;
        issue(1'b0, f3, addr, 32'h0, lat, rdata, err, n_wr, wr_cyc, wa, wd);
        check({tag, "_lat"}, lat, 32'd2);
        check({tag, "_data"}, rdata, exp);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_nowr"}, n_wr, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int exp_lat,
                            input logic [31:0] exp_word);
        int lat, n_wr, wr_cyc;
        logic [31:0] rdata, wa, wd;
        logic err;
        issue(1'b1, f3, addr, wdata, lat, rdata, err, n_wr, wr_cyc, wa, wd);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_nwr"}, n_wr, 32'd1);
        check({tag, "_wrcyc"}, wr_cyc, exp_lat - 1);
        check({tag, "_wraddr"}, wa, {2'b00, addr[31:2]});
        check({tag, "_wrdata"}, wd, exp_word);
    endtask

    task automatic do_error(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr);
        int lat, n_wr, wr_cyc;
        logic [31:0] rdata, wa, wd;
        logic err;
        issue(we, f3, addr, 32'hCAFEF00D, lat, rdata, err, n_wr, wr_cyc, wa, wd);
        check({tag, "_lat"}, lat, 32'd1);
        check({tag, "_err"}, {31'b0, err}, 32'd1);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_nowr"}, n_wr, 32'd0);
    endtask

    task automatic check_counters(input string tag);
`ifdef LSU_PERF_CNT_EN
        check({tag, "_loads"}, load_count_o, exp_loads);
        check({tag, "_stores"}, store_count_o, exp_stores);
        check({tag, "_errs"}, err_count_o, exp_errs);
`else
        check({tag, "_loads_off"}, load_count_o, 32'd0);
        check({tag, "_stores_off"}, store_count_o, 32'd0);
        check({tag, "_errs_off"}, err_count_o, 32'd0);
`endif
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_funct3_i = 3'd0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", {31'b0, req_ready_o}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err_o}, 32'd0);
        check("rst_we", {31'b0, mem_write_enable_o}, 32'd0);
        check("rst_addr", mem_address_o, 32'd0);
        check("rst_wdata", mem_write_data_o, 32'd0);
        check_counters("rst_cnt");
        rst_i = 1'b0;

        do_store("sw_100", 3'd2, 32'h100, 32'hDEADBEEF, 2, 32'hDEADBEEF);
        do_load("lw_100", 3'd2, 32'h100, 32'hDEADBEEF);
        do_load("lb_101", 3'd0, 32'h101, 32'hFFFFFFBE);
        do_load("lbu_101", 3'd4, 32'h101, 32'h000000BE);
        do_load("lh_102", 3'd1, 32'h102, 32'hFFFFDEAD);
        do_load("lhu_102", 3'd5, 32'h102, 32'h0000DEAD);
        do_load("lbu_103", 3'd4, 32'h103, 32'h000000DE);
        do_load("lb_100", 3'd0, 32'h100, 32'hFFFFFFEF);

        do_store("sb_102", 3'd0, 32'h102, 32'h00000012, 3, 32'hDE12BEEF);
        do_store("sh_100", 3'd1, 32'h100, 32'hAAAA5678, 3, 32'hDE125678);
        do_load("lw_after_rmw", 3'd2, 32'h100, 32'hDE125678);

        do_error("lh_103", 1'b0, 3'd1, 32'h103);
        do_error("sw_102", 1'b1, 3'd2, 32'h102);
        do_error("ld_f3_3", 1'b0, 3'd3, 32'h100);
        do_error("lw_1000", 1'b0, 3'd2, 32'h1000);
        do_error("st_f3_5", 1'b1, 3'd5, 32'h100);
        do_load("lw_after_err", 3'd2, 32'h100, 32'hDE125678);
        do_load("lw_last_word", 3'd2, 32'hFFC, mem[10'h3FF]);

        // Reset asserted while the SB read cycle is in progress.
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_funct3_i = 3'd0;
        req_addr_i   = 32'h100;
        req_wdata_i  = 32'h000000AA;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("rmw_rd_we", {31'b0, mem_write_enable_o}, 32'd0);
        check("rmw_rd_ready", {31'b0, req_ready_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        check("rst_mid_ready", {31'b0, req_ready_o}, 32'd1);
        check("rst_mid_we", {31'b0, mem_write_enable_o}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            check("rst_mid_no_wr", {31'b0, mem_write_enable_o}, 32'd0);
            check("rst_mid_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        end
        check("rst_mid_addr", mem_address_o, 32'd0);
        rst_i = 1'b0;
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("post_rst_no_wr", {31'b0, mem_write_enable_o}, 32'd0);
            check("post_rst_no_rsp", {31'b0, rsp_valid_o}, 32'd0);
        end
        check("post_rst_ready", {31'b0, req_ready_o}, 32'd1);
        check("rst_mem_word", mem[10'h40], 32'hDE125678);
        check_counters("post_rst_cnt");

        do_load("lw_post_rst", 3'd2, 32'h100, 32'hDE125678);
        do_store("sw_post_rst", 3'd2, 32'h104, 32'h01234567, 2, 32'h01234567);
        do_load("lh_hi_104", 3'd1, 32'h106, 32'h00000123);
        do_error("lw_misal", 1'b0, 3'd2, 32'h101);
        @(negedge clk_i);
        check_counters("final_cnt");

`ifdef LSU_PERF_CNT_EN
        force dut.r_err_count = 32'hFFFFFFFF;
        @(negedge clk_i);
        release dut.r_err_count;
        do_error("wrap_err", 1'b0, 3'd7, 32'h0);
        @(negedge clk_i);
        check("err_count_wrap", err_count_o, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
